// File: rtl/divisor_bk.sv
// divisor_bk: 4-bit unsigned restoring divider, one quotient bit per clock, MSB first.
// Define DIVISOR_BK_ZERO_DETECT_EN to short-circuit b = 0 into a flagged one-cycle result.
module divisor_bk (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] quotient,
   output logic [3:0] remainder,
   output logic       busy,
   output logic       done,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] step_cnt;
   logic [3:0] a_sr;
   logic [3:0] d_reg;
   logic [3:0] r_reg;
   logic       accept;
   logic       finish_zero;
   logic [4:0] t_val;
   logic [5:0] sum;
   logic       borrow;
   logic [3:0] a_next;
   logic [3:0] r_next;
   logic       unused_diff_msb;

   // The accepting edge may also be the done cycle, so only RUN blocks a new start.
   assign accept = start && (state != RUN);

`ifdef DIVISOR_BK_ZERO_DETECT_EN
   logic zero_q;
   logic dbz_q;

   assign finish_zero = zero_q;
   assign div_by_zero = dbz_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else if (accept) begin
         zero_q <= (b == 4'd0);
         dbz_q  <= 1'b0;
      end else if (state == RUN && zero_q) begin
         dbz_q  <= 1'b1;
      end
   end
`else
   assign finish_zero = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (finish_zero || step_cnt == 2'd0) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Trial subtraction; a set carry-out means T >= D and the quotient bit is 1.
   always_comb begin
      t_val  = {r_reg, a_sr[3]};
      sum    = {1'b0, t_val} + {1'b0, ~{1'b0, d_reg}} + 6'd1;
      borrow = ~sum[5];
      r_next = borrow ? t_val[3:0] : sum[3:0];
      a_next = {a_sr[2:0], ~borrow};
   end

   // R stays below D, so difference bit 4 carries no information.
   assign unused_diff_msb = sum[4];

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr      <= 4'd0;
         d_reg     <= 4'd0;
         r_reg     <= 4'd0;
         step_cnt  <= 2'd0;
         quotient  <= 4'd0;
         remainder <= 4'd0;
      end else if (accept) begin
         a_sr     <= a;
         d_reg    <= b;
         r_reg    <= 4'd0;
         step_cnt <= 2'd3;
      end else if (state == RUN) begin
         if (finish_zero) begin
            quotient  <= 4'hF;
            remainder <= a_sr;
         end else begin
            a_sr     <= a_next;
            r_reg    <= r_next;
            step_cnt <= step_cnt - 2'd1;
            if (step_cnt == 2'd0) begin
               quotient  <= a_next;
               remainder <= r_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_divisor_bk.sv
// tb_divisor_bk: directed and random checks of divisor_bk against an arithmetic
// reference (a / b, a % b, with b = 0 giving 4'hF and a).
module tb_divisor_bk;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int vectors     = 0;
   int miscompares = 0;

`ifdef DIVISOR_BK_ZERO_DETECT_EN
   localparam bit ZD = 1'b1;
`else
   localparam bit ZD = 1'b0;
`endif

   divisor_bk dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference behaviour straight from the arithmetic definition.
   function automatic void model(input int x, input int y, output int q, output int r,
                                 output int dz, output int lat);
      if (y == 0) begin
         q = 15;
         r = x;
      end else begin
         q = x / y;
         r = x % y;
      end
      dz  = (ZD && y == 0) ? 1 : 0;
      lat = (ZD && y == 0) ? 1 : 4;
   endfunction

   // Called at a falling edge; the following rising edge is the accept edge.
   task automatic applyStimulus(input int x, input int y, input bit keep_start);
      a     = 4'(x);
      b     = 4'(y);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep_start) start = 1'b0;
      checkOutput("busy_after_accept", 8'(busy), 8'd1);
      checkOutput("no_done_after_accept", 8'(done), 8'd0);
   endtask

   // Waits (bounded) for done and checks the result; returns at the done falling edge.
   task automatic waitResult(input int x, input int y, input bit scramble);
      int q, r, dz, lat;
      int edges = 0;
      model(x, y, q, r, dz, lat);
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (scramble && !done) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
         end
      end while (!done && edges < 20);
      if (scramble) start = 1'b0;
      checkOutput("latency", 8'(edges), 8'(lat));
      checkOutput("quotient", 8'(quotient), 8'(q));
      checkOutput("remainder", 8'(remainder), 8'(r));
      checkOutput("div_by_zero", 8'(div_by_zero), 8'(dz));
      checkOutput("busy_at_done", 8'(busy), 8'd0);
   endtask

   task automatic checkDrop();
      @(posedge clk);
      @(negedge clk);
      checkOutput("done_pulse_ends", 8'(done), 8'd0);
      checkOutput("idle_after_done", 8'(busy), 8'd0);
   endtask

   initial begin
      $display("[TB] divisor_bk bench, zero detect = %0d", ZD);
      rst   = 1'b1;
      start = 1'b0;
      a     = 4'd0;
      b     = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_quotient", 8'(quotient), 8'd0);
      checkOutput("reset_remainder", 8'(remainder), 8'd0);
      checkOutput("reset_busy", 8'(busy), 8'd0);
      checkOutput("reset_done", 8'(done), 8'd0);
      checkOutput("reset_dbz", 8'(div_by_zero), 8'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases, including divide by zero.
      applyStimulus(13, 3, 1'b0); waitResult(13, 3, 1'b0); checkDrop();
      applyStimulus(15, 1, 1'b0); waitResult(15, 1, 1'b0); checkDrop();
      applyStimulus(2, 7, 1'b0);  waitResult(2, 7, 1'b0);  checkDrop();
      applyStimulus(0, 5, 1'b0);  waitResult(0, 5, 1'b0);  checkDrop();
      applyStimulus(9, 0, 1'b0);  waitResult(9, 0, 1'b0);  checkDrop();

      // start held and operands disturbed during RUN must not matter.
      applyStimulus(12, 5, 1'b1); waitResult(12, 5, 1'b1); checkDrop();

      // Reset in the middle of an operation.
      applyStimulus(14, 4, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 8'(busy), 8'd0);
      checkOutput("abort_done", 8'(done), 8'd0);
      checkOutput("abort_quotient", 8'(quotient), 8'd0);
      checkOutput("abort_remainder", 8'(remainder), 8'd0);
      checkOutput("abort_dbz", 8'(div_by_zero), 8'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_stays_idle", 8'(busy), 8'd0);
      applyStimulus(14, 4, 1'b0); waitResult(14, 4, 1'b0); checkDrop();

      // Back-to-back: second start issued on the done cycle.
      applyStimulus(7, 2, 1'b0);  waitResult(7, 2, 1'b0);
      applyStimulus(8, 3, 1'b0);  waitResult(8, 3, 1'b0);  checkDrop();

      // Random operands; odd iterations chain the next start onto the done cycle.
      for (int i = 0; i < 24; i++) begin
         int x, y;
         x = int'($urandom_range(0, 15));
         y = (i % 6 == 0) ? 0 : int'($urandom_range(0, 15));
         applyStimulus(x, y, 1'b0);
         waitResult(x, y, 1'b0);
         if (i % 2 == 0) checkDrop();
      end
      checkDrop();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/divisor_bk.md
# divisor_bk

Sequential 4-bit unsigned restoring divider for the ALU datapath. It is the consumer-side counterpart of the subtractor: it subtracts repeatedly and uses the borrow to produce the quotient. The block takes a dividend and divisor with a start pulse. It produces quotient and remainder after a fixed, bit-serial iteration, one quotient bit per clock, MSB first.

## Interface
- Parameters: none. Width is fixed at 4 bits.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy = 0.
- a  input  4  dividend; captured on the accepting edge.
- b  input  4  divisor; captured on the accepting edge.
- quotient  output  4  registered quotient; valid from the done cycle onward.
- remainder  output  4  registered remainder; valid from the done cycle onward.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  high with done when the captured b = 0 (see Configuration); held with the results.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: iterating; a 2-bit step counter runs 3 down to 0.
  - DONE: done = 1 for one cycle, then returns to IDLE.
- Accept: an edge with start = 1 and busy = 0 loads internal state and enters RUN.
  - Captures the dividend shift register A = a and the divisor D = b.
  - Clears the partial remainder R[4:0] = 0.
  - Sets the counter to 3.
- Step, once per RUN edge:
  - T = {R[3:0], A[3]}.
  - diff = T + ~{1'b0, D} + 1, computed 5-bit with carry-out.
  - borrow = ~carry_out.
  - If borrow = 0: R = diff, else R = T.
  - A = {A[2:0], ~borrow}, so the quotient bit enters at the LSB.
- After the 4th step:
  - quotient = A, remainder = R[3:0], registered.
  - State goes to DONE.
- Arithmetic:
  - R never exceeds D − 1 after a step, so 5 bits suffice.
  - All operands are unsigned.
- start while busy = 1 is ignored; no queueing.
- Changes on a and b after acceptance have no effect.
- quotient, remainder and div_by_zero hold until the next accepted start.
- In DONE, busy = 0, so start may be accepted on the done cycle (back-to-back).
- rst during RUN or DONE aborts immediately; any partial result is discarded.

## Timing
- Reset values: quotient = 0, remainder = 0, busy = 0, done = 0, div_by_zero = 0, state = IDLE.
- Start accepted at edge E0:
  - busy = 1 after E0.
  - Steps occur at E1 through E4.
  - After E4: done = 1, busy = 0, and results are valid.
  - After E5: done = 0.
- Latency is 4 cycles from the accept edge to done. Maximum throughput is one result per 5 cycles.
- A start accepted on the done cycle (at E5) makes busy = 1 after E5 and done = 0.

## Configuration
- Macro: DIVISOR_BK_ZERO_DETECT_EN.
- Defined: b = 0 at acceptance skips RUN and goes straight to DONE at E1.
  - Outputs: quotient = 4'hF, remainder = a, div_by_zero = 1.
  - Latency is 1 cycle.
- Undefined: b = 0 runs the normal 4-step algorithm.
  - The results are naturally quotient = 4'hF and remainder = a.
  - div_by_zero is tied to 0.
  - Latency is 4 cycles.

## Test plan
- a = 13, b = 3, start for 1 cycle -> done exactly 4 cycles after accept; quotient = 4, remainder = 1, div_by_zero = 0.
- Sweep: a = 15, b = 1 -> quotient 15, remainder 0; a = 2, b = 7 -> quotient 0, remainder 2; a = 0, b = 5 -> quotient 0, remainder 0.
- a = 9, b = 0:
  - With macro: done 1 cycle after accept; quotient 4'hF, remainder 9, div_by_zero = 1.
  - Without macro: done after 4 cycles; same quotient and remainder, div_by_zero = 0.
- Start 12/5, then hold start = 1 while changing a and b during RUN -> a single done; quotient 2, remainder 2; no second accept until busy = 0.
- Start 14/4, assert rst at step 2 -> all outputs 0 next cycle and state IDLE; a new start 14/4 then yields quotient 3, remainder 2.
- Back-to-back: 7/2, with a new start 8/3 asserted on its done cycle -> first result quotient 3, remainder 1; second done 5 cycles later with quotient 2, remainder 2.
